// File: rtl/di_term_mux_if.sv
// di_term_mux_if: host-side DI bus between HostInterface and di_term_mux.
// master = host (address, modes, strobes); slave = mux (data, ready, status).
interface di_term_mux_if;
    logic [15:0] di_term_addr;
    logic        di_read_mode;
    logic        di_write_mode;
    logic        di_read_req;
    logic        di_read;
    logic        di_write;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy;
    logic        di_write_rdy;
    logic [15:0] di_transfer_status;

    modport master (
        output di_term_addr, di_read_mode, di_write_mode,
        output di_read_req, di_read, di_write,
        input  di_reg_datao, di_read_rdy, di_write_rdy,
        input  di_transfer_status
    );

    modport slave (
        input  di_term_addr, di_read_mode, di_write_mode,
        input  di_read_req, di_read, di_write,
        output di_reg_datao, di_read_rdy, di_write_rdy,
        output di_transfer_status
    );
endinterface

// File: rtl/di_term_mux.sv
// di_term_mux: N-terminal DI multiplexer with registered read data and an
// optional ready-timeout watchdog (enabled by DI_TERM_MUX_TIMEOUT_EN).
// Ports: ifclk/resetb (async active-low), host (di_term_mux_if.slave),
// t_sel/t_read_req/t_read/t_write out, t_reg_datao/t_read_rdy/t_write_rdy/
// t_transfer_status in (NUM_TERMS wide, 16 bits per terminal for buses).
module di_term_mux #(
    parameter int unsigned NUM_TERMS = 4,
    parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS =
        {16'd3, 16'd2, 16'd1, 16'd0},
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      ifclk,
    input  logic                      resetb,
    di_term_mux_if.slave              host,
    output logic [NUM_TERMS-1:0]      t_sel,
    output logic [NUM_TERMS-1:0]      t_read_req,
    output logic [NUM_TERMS-1:0]      t_read,
    output logic [NUM_TERMS-1:0]      t_write,
    input  logic [NUM_TERMS*16-1:0]   t_reg_datao,
    input  logic [NUM_TERMS-1:0]      t_read_rdy,
    input  logic [NUM_TERMS-1:0]      t_write_rdy,
    input  logic [NUM_TERMS*16-1:0]   t_transfer_status
);

    logic [NUM_TERMS-1:0] hit_oh;
    logic                 found;
    logic                 unmapped;
    logic [15:0]          sel_data;
    logic [13:0]          sel_stat;
    logic                 sel_rrdy;
    logic                 sel_wrdy;
    logic                 timed_out;
    logic                 gate;
    logic [15:0]          dato_d;
    logic [15:0]          dato_q;
    logic [2*NUM_TERMS-1:0] unused_stat_hi;

    // Lowest matching index wins when the table holds duplicates.
    always_comb begin
        hit_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (!found && TERM_ADDRS[16*i +: 16] == host.di_term_addr) begin
                hit_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign unmapped = ~found;

    // AND-OR mux: everything reads as zero when no terminal is selected.
    always_comb begin
        sel_data = '0;
        sel_stat = '0;
        sel_rrdy = 1'b0;
        sel_wrdy = 1'b0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            sel_data = sel_data | (t_reg_datao[16*i +: 16] & {16{hit_oh[i]}});
            sel_stat = sel_stat
                     | (t_transfer_status[16*i +: 14] & {14{hit_oh[i]}});
            sel_rrdy = sel_rrdy | (t_read_rdy[i] & hit_oh[i]);
            sel_wrdy = sel_wrdy | (t_write_rdy[i] & hit_oh[i]);
        end
    end

    always_comb begin
        unused_stat_hi = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            unused_stat_hi[2*i +: 2] = t_transfer_status[16*i+14 +: 2];
        end
    end

`ifdef DI_TERM_MUX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_TIMEOUT
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   addr_q;
    logic          mode;
    logic          rdy;
    logic          addr_chg;

    assign mode     = host.di_read_mode | host.di_write_mode;
    assign rdy      = host.di_read_mode ? sel_rrdy : sel_wrdy;
    assign addr_chg = host.di_term_addr != addr_q;

    // Counter leaves for TIMEOUT at CNT_LAST, so it can never wrap.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            addr_q <= host.di_term_addr;
            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (mode) state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (!mode) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (unmapped) begin
                        cnt_q <= cnt_q;
                    end else if (addr_chg || rdy) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_TIMEOUT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_TIMEOUT: begin
                    cnt_q <= '0;
                    if (!mode) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign timed_out = (state_q == S_TIMEOUT);
`else
    logic unused_cfg;

    assign timed_out  = 1'b0;
    assign unused_cfg = ^{TIMEOUT_CYCLES, host.di_read_mode,
                          host.di_write_mode};
`endif

    // resetb also gates the combinational paths so outputs read zero in reset.
    assign gate = resetb & ~timed_out;

    assign t_sel      = hit_oh & {NUM_TERMS{resetb}};
    assign t_read_req = hit_oh & {NUM_TERMS{host.di_read_req & gate}};
    assign t_read     = hit_oh & {NUM_TERMS{host.di_read & gate}};
    assign t_write    = hit_oh & {NUM_TERMS{host.di_write & gate}};

    assign host.di_read_rdy  = resetb & (timed_out | unmapped | sel_rrdy);
    assign host.di_write_rdy = resetb & (timed_out | unmapped | sel_wrdy);

    assign host.di_transfer_status =
        resetb ? {timed_out, unmapped, sel_stat} : 16'h0000;

    assign dato_d = timed_out ? 16'hDEAD : sel_data;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) dato_q <= '0;
        else         dato_q <= dato_d;
    end

    assign host.di_reg_datao = dato_q;

endmodule

// File: tb/tb_di_term_mux.sv
// tb_di_term_mux: scoreboard bench for di_term_mux with a behavioural model.
// Driver pushes expected outputs per cycle; a negedge monitor pops/compares.
`timescale 1ns/1ps
module tb_di_term_mux;
    localparam int N  = 4;
    localparam int TC = 8;
`ifdef DI_TERM_MUX_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic ifclk = 1'b0;
    logic resetb = 1'b0;
    always #5 ifclk = ~ifclk;

    di_term_mux_if host();
    logic [N-1:0]    t_sel, t_read_req, t_read, t_write;
    logic [N-1:0]    t_read_rdy, t_write_rdy;
    logic [N*16-1:0] t_reg_datao, t_transfer_status;

    di_term_mux #(
        .NUM_TERMS(N),
        .TERM_ADDRS({16'd3, 16'd2, 16'd1, 16'd0}),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .ifclk(ifclk),
        .resetb(resetb),
        .host(host),
        .t_sel(t_sel),
        .t_read_req(t_read_req),
        .t_read(t_read),
        .t_write(t_write),
        .t_reg_datao(t_reg_datao),
        .t_read_rdy(t_read_rdy),
        .t_write_rdy(t_write_rdy),
        .t_transfer_status(t_transfer_status)
    );

    typedef struct {
        logic [N-1:0] sel, rreq, rd, wr;
        logic         rrdy, wrdy;
        logic [15:0]  stat, dat;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] addr_tab [N] = '{16'd0, 16'd1, 16'd2, 16'd3};

    bit          m_to;
    bit          m_act;
    int          m_run;
    logic [15:0] m_prev;
    logic [15:0] m_dat;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_to   = 1'b0;
        m_act  = 1'b0;
        m_run  = 0;
        m_prev = 16'h0;
        m_dat  = 16'h0;
    endtask

    always @(negedge ifclk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("t_sel", 32'(t_sel), 32'(e.sel));
            chk("t_read_req", 32'(t_read_req), 32'(e.rreq));
            chk("t_read", 32'(t_read), 32'(e.rd));
            chk("t_write", 32'(t_write), 32'(e.wr));
            chk("read_rdy", 32'(host.di_read_rdy), 32'(e.rrdy));
            chk("write_rdy", 32'(host.di_write_rdy), 32'(e.wrdy));
            chk("status", 32'(host.di_transfer_status), 32'(e.stat));
            chk("datao", 32'(host.di_reg_datao), 32'(e.dat));
        end
    end

    task automatic rand_terms();
        for (int i = 0; i < N; i++) begin
            t_reg_datao[16*i +: 16]       = 16'($urandom);
            t_transfer_status[16*i +: 16] = 16'($urandom);
        end
    endtask

    // Applies one cycle of host inputs, predicts outputs, advances model.
    task automatic step(input logic [15:0] addr, input logic rm, wm,
                        input logic rq, r, w);
        exp_t         e;
        int           s;
        logic [N-1:0] oh;
        bit           um;
        logic         rdy;
        host.di_term_addr  = addr;
        host.di_read_mode  = rm;
        host.di_write_mode = wm;
        host.di_read_req   = rq;
        host.di_read       = r;
        host.di_write      = w;
        s = -1;
        for (int i = N-1; i >= 0; i--) if (addr_tab[i] == addr) s = i;
        um = (s < 0);
        oh = '0;
        if (!um) oh[s] = 1'b1;
        e.sel  = oh;
        e.rreq = m_to ? '0 : (oh & {N{rq}});
        e.rd   = m_to ? '0 : (oh & {N{r}});
        e.wr   = m_to ? '0 : (oh & {N{w}});
        if (m_to || um) begin
            e.rrdy = 1'b1;
            e.wrdy = 1'b1;
            e.stat = {m_to, um, 14'h0};
            if (!um) e.stat[13:0] = t_transfer_status[16*s +: 14];
        end else begin
            e.rrdy = t_read_rdy[s];
            e.wrdy = t_write_rdy[s];
            e.stat = {1'b0, 1'b0, t_transfer_status[16*s +: 14]};
        end
        e.dat = m_dat;
        q.push_back(e);
        if (m_to)      m_dat = 16'hDEAD;
        else if (um)   m_dat = 16'h0000;
        else           m_dat = t_reg_datao[16*s +: 16];
        if (WD) begin
            rdy = um ? 1'b0 : (rm ? t_read_rdy[s] : t_write_rdy[s]);
            if (!(rm | wm)) begin
                m_to  = 1'b0;
                m_act = 1'b0;
                m_run = 0;
            end else if (m_to) begin
                m_run = 0;
            end else if (!m_act) begin
                m_act = 1'b1;
                m_run = 0;
            end else if (um) begin
                m_run = m_run;
            end else if (addr != m_prev || rdy) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == TC) m_to = 1'b1;
            end
        end
        m_prev = addr;
        @(posedge ifclk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_t_sel"}, 32'(t_sel), 32'h0);
        chk({tag, "_t_read_req"}, 32'(t_read_req), 32'h0);
        chk({tag, "_t_read"}, 32'(t_read), 32'h0);
        chk({tag, "_t_write"}, 32'(t_write), 32'h0);
        chk({tag, "_read_rdy"}, 32'(host.di_read_rdy), 32'h0);
        chk({tag, "_write_rdy"}, 32'(host.di_write_rdy), 32'h0);
        chk({tag, "_status"}, 32'(host.di_transfer_status), 32'h0);
        chk({tag, "_datao"}, 32'(host.di_reg_datao), 32'h0);
    endtask

    initial begin
        logic [15:0] a;
        logic [1:0]  md;
        int          len;
        int          pick;

        model_reset();
        rand_terms();
        t_read_rdy  = '1;
        t_write_rdy = '1;
        host.di_term_addr  = 16'd2;
        host.di_read_mode  = 1'b1;
        host.di_write_mode = 1'b1;
        host.di_read_req   = 1'b1;
        host.di_read       = 1'b1;
        host.di_write      = 1'b1;
        #12;
        check_reset_outputs("por");
        @(posedge ifclk);
        #1;
        resetb = 1'b1;

        // Read of terminal 2 returns its data one cycle later.
        t_reg_datao[32 +: 16] = 16'h1234;
        t_read_rdy = 4'b0100;
        step(16'd2, 1, 0, 1, 1, 0);
        step(16'd2, 1, 0, 0, 0, 0);
        step(16'd2, 0, 0, 0, 0, 0);

        // Unmapped write is dropped and reports ready.
        rand_terms();
        step(16'h00FF, 0, 1, 0, 0, 1);
        step(16'h00FF, 0, 1, 0, 0, 1);
        step(16'h00FF, 0, 0, 0, 0, 0);

        // Terminal 1 never ready during a read transfer, then mode drop.
        t_read_rdy = 4'b1101;
        for (int k = 0; k < 12; k++) begin
            rand_terms();
            step(16'd1, 1, 0, 1, 1, 0);
        end
        step(16'd1, 0, 0, 0, 0, 0);
        step(16'd1, 0, 0, 0, 0, 0);

        // Ready low for 7 cycles then high, repeated.
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 8; k++) begin
                t_read_rdy = (k == 7) ? 4'b1111 : 4'b1101;
                rand_terms();
                step(16'd1, 1, 0, 0, 1, 0);
            end
        end
        step(16'd1, 0, 0, 0, 0, 0);

        // Long not-ready stretch on terminal 3.
        t_read_rdy = 4'b0111;
        for (int k = 0; k < 2000; k++) step(16'd3, 1, 0, 0, 1, 0);
        step(16'd3, 0, 0, 0, 0, 0);

        // Randomized bursts.
        for (int b = 0; b < 80; b++) begin
            pick = $urandom_range(0, 9);
            if (pick < 8)       a = addr_tab[pick % N];
            else if (pick == 8) a = 16'h00FF;
            else                a = 16'($urandom);
            md  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 25);
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < N; i++) begin
                    t_read_rdy[i]  = ($urandom_range(0, 9) == 0);
                    t_write_rdy[i] = ($urandom_range(0, 9) == 0);
                end
                rand_terms();
                if ($urandom_range(0, 19) == 0)
                    a = addr_tab[$urandom_range(0, N-1)];
                step(a, md[0], md[1], 1'($urandom), 1'($urandom),
                     1'($urandom));
            end
        end
        step(16'd0, 0, 0, 0, 0, 0);

        // Reset asserted mid-transfer (in TIMEOUT when the watchdog exists).
        t_read_rdy = 4'b1101;
        for (int k = 0; k < 10; k++) step(16'd1, 1, 0, 1, 1, 1);
        chk("queue_drained", 32'(q.size()), 32'h0);
        #2;
        resetb = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge ifclk);
        #1;
        check_reset_outputs("held_rst");
        model_reset();
        resetb = 1'b1;
        t_read_rdy = '1;
        for (int k = 0; k < 4; k++) begin
            rand_terms();
            step(16'd0, 1, 0, 1, 1, 0);
        end
        step(16'd0, 0, 0, 0, 0, 0);
        chk("final_drain", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/di_term_mux.md
# di_term_mux

Parametrised N-terminal device-interface (DI) multiplexer that sits between HostInterface and the terminal instances in an FPGA top level.
- Decodes `di_term_addr` against a table of terminal addresses.
- Steers the host read/write strobes to the selected terminal.
- Returns that terminal's data, ready flags and status with registered read data.
- Adds a per-transfer ready-timeout watchdog, so a terminal that never asserts ready cannot hang the host.

## Interface
Parameters:
- `NUM_TERMS`, 4: number of terminals, 1–16.
- `TERM_ADDRS`, {16'd3,16'd2,16'd1,16'd0}: NUM_TERMS×16 packed address table; entry i is at bits [16i+15:16i].
- `TIMEOUT_CYCLES`, 1024: consecutive not-ready cycles before timeout, 2–65535.

Ports:
- `ifclk`  in  1  sole clock.
- `resetb`  in  1  asynchronous active-low reset.
- `di_term_addr`  in  16  terminal address from host.
- `di_read_mode`  in  1  read transfer in progress.
- `di_write_mode`  in  1  write transfer in progress.
- `di_read_req`  in  1  host read request strobe.
- `di_read`  in  1  host read strobe.
- `di_write`  in  1  host write strobe.
- `di_reg_datao`  out  16  read data to host, registered.
- `di_read_rdy`  out  1  read ready to host.
- `di_write_rdy`  out  1  write ready to host.
- `di_transfer_status`  out  16  status to host.
- `t_sel`  out  NUM_TERMS  one-hot terminal select.
- `t_read_req`, `t_read`, `t_write`  out  NUM_TERMS each  per-terminal gated strobes.
- `t_reg_datao`  in  NUM_TERMS×16  terminal read data.
- `t_read_rdy`, `t_write_rdy`  in  NUM_TERMS each  terminal ready flags.
- `t_transfer_status`  in  NUM_TERMS×16  terminal status.

## Operation
- Decode (combinational):
  - `sel` is the lowest index i with `TERM_ADDRS[i]` == `di_term_addr`.
  - No match: `unmapped`=1, `t_sel`=0.
- Strobe gating:
  - `t_read_req[i]`, `t_read[i]` and `t_write[i]` equal the host strobe AND `t_sel[i]` AND state≠TIMEOUT.
  - Unmapped writes are dropped.
- Read data: each cycle `di_reg_datao` <= `t_reg_datao[sel]`.
  - Unmapped: 16'h0000.
  - TIMEOUT: 16'hDEAD.
- Ready flags:
  - IDLE/ACTIVE: pass through from `sel`.
  - Unmapped: both 1.
  - TIMEOUT: both 1.
- Status: `di_transfer_status` = {timed_out, unmapped, `t_transfer_status[sel]`[13:0]}.
  - Lower 14 bits are 0 when unmapped.
- Watchdog FSM, with `mode` = `di_read_mode`|`di_write_mode` and `rdy` = read_rdy if read_mode, else write_rdy, taken from `sel`:
  - IDLE: enter ACTIVE when `mode`=1. Counter=0.
  - ACTIVE:
    - `rdy`=1: counter cleared.
    - `rdy`=0: counter increments.
    - Counter reaches TIMEOUT_CYCLES−1 while `rdy`=0: go to TIMEOUT.
    - `mode`=0: go to IDLE.
    - Unmapped: counter does not run.
  - TIMEOUT: `timed_out`=1. Leave to IDLE only when `mode`=0.
  - A change of `di_term_addr` mid-transfer clears the counter but does not exit TIMEOUT.
- Counter width: clog2(TIMEOUT_CYCLES). It saturates and never wraps.

## Timing
- Reset values:
  - `di_reg_datao`=0, `di_read_rdy`=0, `di_write_rdy`=0, `di_transfer_status`=0.
  - `t_*` strobes=0, `t_sel`=0.
  - FSM=IDLE, counter=0.
  - While `resetb`=0, all outputs are held at these values.
- Latency:
  - `di_reg_datao`: 1 cycle after the terminal data.
  - Ready, strobes, `t_sel` and status: combinational, 0 cycles.
- Timeout timing: the TIMEOUT state is entered on the edge that ends exactly TIMEOUT_CYCLES consecutive not-ready cycles. Ready is forced high in the following cycle.
- Simultaneous events:
  - `rdy` rising in the same cycle the count completes: `rdy` wins and the count clears.
  - `mode` falling in the same cycle: IDLE wins.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately and asynchronously, and `timed_out` clears.

## Configuration
- `DI_TERM_MUX_TIMEOUT_EN` defined: watchdog FSM and counter are present as described.
- Undefined:
  - No FSM or counter.
  - State is permanently IDLE and `timed_out` is always 0.
  - Ready flags are pure pass-through, or 1 when unmapped.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Terminal 2 at addr 2 drives data 16'h1234, read_rdy=1; host reads addr 2 -> `di_reg_datao`=16'h1234 one cycle later, `t_read[2]` pulses, other `t_read` bits stay 0.
- Host writes addr 16'h00FF (unmapped) -> `di_write_rdy`=1, all `t_write`=0, `di_transfer_status`=16'h4000.
- TIMEOUT_CYCLES=8, terminal 1 read_rdy held 0 under read_mode -> TIMEOUT after 8 cycles: `di_read_rdy`=1, data 16'hDEAD, status bit15=1; mode drop -> IDLE, bit15=0.
- Terminal ready toggles 0 for 7 cycles, then 1, repeated, with TIMEOUT_CYCLES=8 -> never enters TIMEOUT.
- Assert `resetb`=0 while in TIMEOUT -> all outputs 0 asynchronously; after release, a read of addr 0 behaves normally.
- With `DI_TERM_MUX_TIMEOUT_EN` undefined, ready held 0 for 2000 cycles -> `di_read_rdy` stays 0 and status bit15 stays 0.
